// File: rtl/stop_watch_lap.sv
// BCD stopwatch / count-down timer with lap freeze, preload and sticky overflow.
// digits shows either the live count or the value frozen by the last lap press.
module stop_watch_lap #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 10_000_000,
    parameter int TW         = $clog2(TICK_DIV)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    go,
    input  logic                    clr,
    input  logic                    lap,
    input  logic                    down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    running,
    output logic                    lap_active,
    output logic                    done,
    output logic                    overflow
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Returns {carry_out, value + 1}; carry_out marks the all-9s wrap.
    function automatic logic [DW:0] bcd_inc(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (c) begin
                if (v[4*k +: 4] >= 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    c = 1'b0;
                end
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return {c, r};
    endfunction

    function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (b) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    b = 1'b0;
                end
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] bcd_sat(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                r[4*k +: 4] = 4'd9;
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [DW-1:0] count_q, count_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          lap_prev_q, lap_prev_d;
    logic          lap_act_q, lap_act_d;
    logic [DW-1:0] lap_reg_q, lap_reg_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;

    logic          tick_s;
    logic          lap_rise_s;
    logic [DW:0]   inc_s;
    logic [DW-1:0] dec_s;

    assign tick_s     = (state_q == RUN) && (tick_q == TICK_LAST);
    assign lap_rise_s = lap & ~lap_prev_q;
    assign inc_s      = bcd_inc(count_q);
    assign dec_s      = bcd_dec(count_q);

    // Next-state: clr beats load beats run/pause logic; lap toggling runs alongside load and stepping.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        count_d    = count_q;
        tick_d     = tick_q;
        lap_prev_d = lap;
        lap_act_d  = lap_act_q;
        lap_reg_d  = lap_reg_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        if (clr) begin
            state_d   = IDLE;
            count_d   = '0;
            tick_d    = '0;
            lap_act_d = 1'b0;
            ovf_d     = 1'b0;
        end else begin
            // The freeze captures the pre-step count, since count_d is not involved.
            if (lap_rise_s) begin
                lap_act_d = ~lap_act_q;
                lap_reg_d = lap_act_q ? lap_reg_q : count_q;
            end else begin
                lap_act_d = lap_act_q;
            end
            if (load && (state_q != RUN)) begin
                count_d = bcd_sat(load_val);
                tick_d  = '0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE, PAUSE: begin
                        if (go) begin
                            state_d = RUN;
                            mode_d  = down;
                        end else begin
                            state_d = state_q;
                        end
                    end
                    RUN: begin
                        if (mode_q && (count_q == '0)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            tick_d = tick_s ? '0 : tick_q + TW'(1);
                            if (tick_s) begin
                                if (mode_q) begin
                                    count_d = dec_s;
                                end else begin
                                    count_d = inc_s[DW-1:0];
                                    ovf_d   = ovf_q | inc_s[DW];
                                end
                            end else begin
                                count_d = count_q;
                            end
                            if (tick_s && mode_q && (dec_s == '0)) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else if (!go) begin
                                state_d = PAUSE;
                            end else begin
                                state_d = RUN;
                            end
                        end
                    end
                    DONE: begin
                        state_d = DONE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            count_q    <= '0;
            tick_q     <= '0;
            lap_prev_q <= 1'b0;
            lap_act_q  <= 1'b0;
            lap_reg_q  <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            count_q    <= count_d;
            tick_q     <= tick_d;
            lap_prev_q <= lap_prev_d;
            lap_act_q  <= lap_act_d;
            lap_reg_q  <= lap_reg_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign digits     = lap_act_q ? lap_reg_q : count_q;
    assign running    = (state_q == RUN);
    assign lap_active = lap_act_q;
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_stop_watch_lap.sv
// Self-checking bench for stop_watch_lap: integer-level reference model, directed scenarios
// and a randomized soak, all compared cycle by cycle.
module tb_stop_watch_lap;

    localparam int ND = 4;
    localparam int TD = 4;
    localparam int M  = 10000;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic          clk = 1'b0;
    logic          reset, go, clr, lap, down, load;
    logic [15:0]   load_val;
    logic [15:0]   digits;
    logic          running, lap_active, done, overflow;

    int n_vec = 0;
    int n_err = 0;

    int m_count, m_tick, m_state, m_lap_val;
    bit m_mode, m_lap_prev, m_lap_act, m_done, m_ovf;

    stop_watch_lap #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .go(go), .clr(clr), .lap(lap), .down(down),
        .load(load), .load_val(load_val), .digits(digits), .running(running),
        .lap_active(lap_active), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    wire [19:0] act_vec = {digits, running, lap_active, done, overflow};

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int sat_val(input logic [15:0] v);
        int s, p, d;
        s = 0;
        p = 1;
        for (int k = 0; k < ND; k++) begin
            d = int'(v[4*k +: 4]);
            if (d > 9) d = 9;
            s = s + d * p;
            p = p * 10;
        end
        return s;
    endfunction

    function automatic logic [19:0] exp_vec();
        return {to_bcd(m_lap_act ? m_lap_val : m_count), (m_state == S_RUN), m_lap_act, m_done, m_ovf};
    endfunction

    task automatic model_step();
        bit rise, tk;
        if (reset) begin
            m_count = 0; m_tick = 0; m_state = S_IDLE; m_mode = 0;
            m_lap_prev = 0; m_lap_act = 0; m_lap_val = 0; m_done = 0; m_ovf = 0;
            return;
        end
        rise = lap && !m_lap_prev;
        m_lap_prev = lap;
        m_done = 0;
        if (clr) begin
            m_count = 0; m_tick = 0; m_lap_act = 0; m_ovf = 0; m_state = S_IDLE;
            return;
        end
        if (rise) begin
            if (!m_lap_act) m_lap_val = m_count;
            m_lap_act = !m_lap_act;
        end
        if (load && m_state != S_RUN) begin
            m_count = sat_val(load_val); m_tick = 0; m_ovf = 0; m_state = S_IDLE;
        end else if (m_state == S_IDLE || m_state == S_PAUSE) begin
            if (go) begin m_state = S_RUN; m_mode = down; end
        end else if (m_state == S_RUN) begin
            if (m_mode && m_count == 0) begin
                m_state = S_DONE; m_done = 1;
            end else begin
                tk = (m_tick == TD - 1);
                m_tick = tk ? 0 : m_tick + 1;
                if (tk && m_mode) m_count = m_count - 1;
                if (tk && !m_mode) begin
                    if (m_count == M - 1) m_ovf = 1;
                    m_count = (m_count + 1) % M;
                end
                if (tk && m_mode && m_count == 0) begin m_state = S_DONE; m_done = 1; end
                else if (!go) m_state = S_PAUSE;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; go = 0; clr = 0; lap = 0; down = 0; load = 0; load_val = 16'h0000;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            reset = 1; go = 1'($urandom); lap = 1'($urandom); clr = 0; load = 0; down = 1'($urandom);
            cyc();
            n_vec++;
            if (act_vec !== 20'h00000 || act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL reset[%0d]: got %h want %h", i, act_vec, exp_vec());
            end
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_basic_count();
        clr = 1; cyc(); clr = 0;
        go = 1;
        for (int i = 0; i < 41; i++) begin
            cyc();
            n_vec++;
            if (act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL basic_count cyc %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        n_vec++;
        if (digits !== 16'h0010 || running !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL basic_count_end: got d=%h r=%b o=%b want d=0010 r=1 o=0", digits, running, overflow);
        end
    endtask

    task automatic test_up_wrap();
        go = 0; cyc(); cyc();
        load = 1; load_val = 16'h9998; down = 0; cyc(); load = 0;
        go = 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_vec++;
            if (act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL up_wrap cyc %0d: got %h want %h", i, act_vec, exp_vec());
            end
            if (i == 8) begin
                n_vec++;
                if (digits !== 16'h0000 || overflow !== 1'b1) begin
                    n_err++;
                    $display("FAIL up_wrap_zero: got d=%h o=%b want d=0000 o=1", digits, overflow);
                end
            end
        end
        go = 0; clr = 1; cyc(); clr = 0;
        n_vec++;
        if (overflow !== 1'b0 || digits !== 16'h0000) begin
            n_err++;
            $display("FAIL up_wrap_clr: got d=%h o=%b want d=0000 o=0", digits, overflow);
        end
    endtask

    task automatic test_count_down();
        int pulses;
        load = 1; load_val = 16'h0003; down = 1; cyc(); load = 0;
        go = 1;
        pulses = 0;
        for (int i = 0; i < 33; i++) begin
            cyc();
            if (done === 1'b1) pulses++;
            n_vec++;
            if (act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL count_down cyc %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        n_vec++;
        if (pulses != 1 || digits !== 16'h0000 || running !== 1'b0) begin
            n_err++;
            $display("FAIL count_down_end: got pulses=%0d d=%h r=%b want 1 0000 0", pulses, digits, running);
        end
        go = 0; clr = 1; cyc(); clr = 0;
        // Entering RUN at zero in down mode finishes immediately.
        go = 1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (done === 1'b1) pulses++;
            n_vec++;
            if (act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL down_from_zero cyc %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL down_from_zero_pulses: got %0d want 1", pulses);
        end
        go = 0; down = 0; clr = 1; cyc(); clr = 0;
    endtask

    task automatic test_lap();
        go = 1;
        for (int i = 0; i < 21; i++) cyc();
        lap = 1; cyc(); lap = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_vec++;
            if (digits !== 16'h0005 || lap_active !== 1'b1 || act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL lap_hold cyc %0d: got %h want %h (digits 0005)", i, act_vec, exp_vec());
            end
        end
        lap = 1; cyc(); lap = 0;
        n_vec++;
        if (digits !== 16'h0007 || lap_active !== 1'b0 || act_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL lap_release: got %h want %h (digits 0007)", act_vec, exp_vec());
        end
        go = 0; clr = 1; cyc(); clr = 0;
    endtask

    task automatic test_pause();
        go = 1;
        for (int i = 0; i < 11; i++) cyc();
        go = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_vec++;
            if (digits !== 16'h0002 || running !== 1'b0 || act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL pause_hold cyc %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        go = 1;
        cyc();
        n_vec++;
        if (digits !== 16'h0002 || running !== 1'b1) begin
            n_err++;
            $display("FAIL pause_resume1: got d=%h r=%b want 0002 1", digits, running);
        end
        cyc();
        n_vec++;
        if (digits !== 16'h0003 || act_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL pause_resume2: got %h want %h (digits 0003)", act_vec, exp_vec());
        end
        go = 0; clr = 1; cyc(); clr = 0;
    endtask

    task automatic test_priority();
        go = 1;
        for (int i = 0; i < 7; i++) cyc();
        clr = 1; load = 1; load_val = 16'h1234; lap = 1;
        cyc();
        clr = 0; load = 0; lap = 0; go = 0;
        n_vec++;
        if (digits !== 16'h0000 || running !== 1'b0 || lap_active !== 1'b0 || act_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL prio_clr: got %h want %h", act_vec, exp_vec());
        end
        go = 1;
        for (int i = 0; i < 9; i++) cyc();
        lap = 1; cyc(); lap = 0; cyc();
        reset = 1; cyc(); reset = 0;
        n_vec++;
        if (act_vec !== 20'h00000 || act_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL prio_reset: got %h want 00000", act_vec);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 499) == 0);
            clr      = ($urandom_range(0, 99) == 0);
            load     = ($urandom_range(0, 39) == 0);
            go       = ($urandom_range(0, 9) != 0);
            lap      = ($urandom_range(0, 11) == 0);
            down     = 1'($urandom);
            load_val = 16'($urandom);
            cyc();
            n_vec++;
            if (act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        m_count = 0; m_tick = 0; m_state = S_IDLE; m_lap_val = 0;
        m_mode = 0; m_lap_prev = 0; m_lap_act = 0; m_done = 0; m_ovf = 0;
        test_reset();
        test_basic_count();
        test_up_wrap();
        test_count_down();
        test_lap();
        test_pause();
        test_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
